// File: rtl/cbs_shaper_gate.sv
// AXI4-Stream credit-based shaper gate for one CBS class queue: zero-latency
// pass-through that holds back new frame starts while the 802.1Qav credit is negative.
module cbs_shaper_gate #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int CREDIT_WIDTH       = 32,
  parameter int SLOPE_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic                          shaper_en,
  input  logic [SLOPE_WIDTH-1:0]        idle_slope,
  input  logic [SLOPE_WIDTH-1:0]        send_slope,
  input  logic [CREDIT_WIDTH-1:0]       hi_credit,
  input  logic [CREDIT_WIDTH-1:0]       lo_credit,
  output logic [CREDIT_WIDTH-1:0]       credit,
  output logic                          credit_negative,
  output logic                          in_frame,
  output logic                          output_side_ready
);

  localparam int EW = CREDIT_WIDTH + 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic signed [CREDIT_WIDTH-1:0] credit_q, credit_d;

  logic                  allow;
  logic                  xfer;
  logic                  vld_gated;
  logic                  rdy_gated;
  logic signed [EW-1:0]  cred_x, idle_x, send_x, hi_x, lo_x, sum_x;

  assign m_axis_tdata      = s_axis_tdata;
  assign m_axis_tkeep      = s_axis_tkeep;
  assign m_axis_tlast      = s_axis_tlast;
  assign output_side_ready = m_axis_tready;

  // Gating looks only at the registered credit so a release lands one cycle after credit >= 0.
  assign allow     = ~shaper_en | ~credit_q[CREDIT_WIDTH-1];
  assign vld_gated = (state_q == SEND) ? s_axis_tvalid : (s_axis_tvalid & allow);
  assign rdy_gated = (state_q == SEND) ? m_axis_tready : (m_axis_tready & allow);

  assign m_axis_tvalid = rstn & vld_gated;
  assign s_axis_tready = rstn & rdy_gated;
  assign xfer          = m_axis_tvalid & m_axis_tready;

  assign cred_x = {{2{credit_q[CREDIT_WIDTH-1]}}, credit_q};
  assign idle_x = {{(EW - SLOPE_WIDTH){1'b0}}, idle_slope};
  assign send_x = {{(EW - SLOPE_WIDTH){1'b0}}, send_slope};
  assign hi_x   = {{2{hi_credit[CREDIT_WIDTH-1]}}, hi_credit};
  assign lo_x   = {{2{lo_credit[CREDIT_WIDTH-1]}}, lo_credit};

  always_comb begin
    sum_x = cred_x;
    if (!shaper_en) begin
      sum_x = '0;
    end else if (xfer) begin
      sum_x = cred_x + idle_x - send_x;
    end else if ((state_q == SEND) || s_axis_tvalid) begin
      sum_x = cred_x + idle_x;
    end else if (cred_x > 0) begin
      sum_x = '0;
    end else if (cred_x < 0) begin
      sum_x = cred_x + idle_x;
      if (sum_x > 0) begin
        sum_x = '0;
      end
    end

    if (sum_x > hi_x) begin
      credit_d = hi_credit;
    end else if (sum_x < lo_x) begin
      credit_d = lo_credit;
    end else begin
      credit_d = sum_x[CREDIT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && !s_axis_tlast) state_d = SEND;
      SEND:    if (xfer && s_axis_tlast)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  assign credit          = credit_q;
  assign credit_negative = credit_q[CREDIT_WIDTH-1];
  assign in_frame        = (state_q == SEND);

endmodule

// File: tb/tb_cbs_shaper_gate.sv
// Self-checking bench for cbs_shaper_gate: beat scoreboard on the output side plus
// cycle-exact credit, gating and status checks for drain, recovery, clamps, reset and disable.
module tb_cbs_shaper_gate;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int CW = 32;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          shaper_en;
  logic [SW-1:0] idle_slope;
  logic [SW-1:0] send_slope;
  logic [CW-1:0] hi_credit;
  logic [CW-1:0] lo_credit;
  logic [CW-1:0] credit;
  logic          credit_negative;
  logic          in_frame;
  logic          output_side_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW+KW:0] sb_q[$];

  cbs_shaper_gate #(
    .C_AXIS_TDATA_WIDTH(DW),
    .C_AXIS_TKEEP_WIDTH(KW),
    .CREDIT_WIDTH      (CW),
    .SLOPE_WIDTH       (SW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .shaper_en        (shaper_en),
    .idle_slope       (idle_slope),
    .send_slope       (send_slope),
    .hi_credit        (hi_credit),
    .lo_credit        (lo_credit),
    .credit           (credit),
    .credit_negative  (credit_negative),
    .in_frame         (in_frame),
    .output_side_ready(output_side_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    sb_q.push_back({last, keep, data});
  endtask

  // Output-side monitor: every accepted beat must match the oldest presented beat.
  always @(negedge clk) begin
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      chk("sb_nonempty", longint'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        chk("beat", longint'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), longint'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    int lo_exp[4];
    lo_exp = '{0, -3, -6, -8};

    rstn          = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    shaper_en     = 1'b1;
    idle_slope    = 16'd1;
    send_slope    = 16'd4;
    hi_credit     = 32'sd100;
    lo_credit     = -32'sd100;

    #3;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_credit", $signed(credit), 0);
    chk("rst_neg", credit_negative, 0);
    chk("rst_in_frame", in_frame, 0);

    tick();
    rstn          = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      drive_beat(16'hA000 + 16'(i), 2'b11, i == 3);
      #2;
      chk("drain_credit", $signed(credit), -3 * i);
      chk("drain_in_frame", in_frame, i > 0);
      chk("drain_tvalid", m_axis_tvalid, 1);
      tick();
    end

    // Second frame straight after: gated until credit climbs back to 0.
    drive_beat(16'hB000, 2'b01, 1'b0);
    for (int c = 0; c < 12; c++) begin
      #2;
      chk("gate_tvalid", m_axis_tvalid, 0);
      chk("gate_tready", s_axis_tready, 0);
      chk("gate_credit", $signed(credit), -12 + c);
      tick();
    end
    #2;
    chk("release_tvalid", m_axis_tvalid, 1);
    chk("release_credit", $signed(credit), 0);
    tick();

    drive_beat(16'hB001, 2'b10, 1'b0);
    m_axis_tready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("bp_osr", output_side_ready, 0);
      chk("bp_tready", s_axis_tready, 0);
      chk("bp_tvalid", m_axis_tvalid, 1);
      chk("bp_credit", $signed(credit), -3 + c);
      tick();
    end
    m_axis_tready = 1'b1;
    #2;
    chk("bp_resume_osr", output_side_ready, 1);
    chk("bp_resume_tvalid", m_axis_tvalid, 1);
    chk("bp_resume_neg", credit_negative, 1);
    chk("bp_resume_credit", $signed(credit), -1);
    tick();
    drive_beat(16'hB002, 2'b11, 1'b0);
    #2;
    chk("bp_b2_credit", $signed(credit), -4);
    tick();
    drive_beat(16'hB003, 2'b11, 1'b1);
    #2;
    chk("bp_b3_credit", $signed(credit), -7);
    tick();
    s_axis_tvalid = 1'b0;
    #2;
    chk("empty_credit", $signed(credit), -10);
    chk("empty_in_frame", in_frame, 0);
    tick();
    #2;
    chk("empty_recover", $signed(credit), -9);

    // Disable with negative credit: ungated at once, credit zeroed on the next edge.
    tick();
    shaper_en = 1'b0;
    drive_beat(16'hC000, 2'b11, 1'b1);
    #2;
    chk("dis_tvalid", m_axis_tvalid, 1);
    chk("dis_credit_before", $signed(credit), -8);
    tick();
    drive_beat(16'hC001, 2'b01, 1'b1);
    #2;
    chk("dis_credit_zero", $signed(credit), 0);
    chk("dis_tvalid2", m_axis_tvalid, 1);
    tick();
    s_axis_tvalid = 1'b0;
    shaper_en     = 1'b1;
    tick();

    lo_credit = -32'sd8;
    for (int i = 0; i < 4; i++) begin
      drive_beat(16'hE000 + 16'(i), 2'b11, i == 3);
      #2;
      chk("lo_credit", $signed(credit), lo_exp[i]);
      tick();
    end
    s_axis_tvalid = 1'b0;
    #2;
    chk("lo_final", $signed(credit), -8);
    repeat (8) tick();
    #2;
    chk("lo_drain_zero", $signed(credit), 0);
    lo_credit = -32'sd100;

    tick();
    hi_credit     = 32'sd5;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'hF000;
    s_axis_tlast  = 1'b1;
    repeat (3) tick();
    #2;
    chk("hi_climb", $signed(credit), 3);
    repeat (7) tick();
    #2;
    chk("hi_sat", $signed(credit), 5);
    chk("hi_osr", output_side_ready, 0);
    s_axis_tvalid = 1'b0;
    tick();
    #2;
    chk("hi_discard", $signed(credit), 0);
    m_axis_tready = 1'b1;
    hi_credit     = 32'sd100;
    tick();

    drive_beat(16'hD000, 2'b11, 1'b0);
    tick();
    drive_beat(16'hD001, 2'b11, 1'b0);
    #2;
    chk("pre_rst_in_frame", in_frame, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tready", s_axis_tready, 0);
    chk("midrst_in_frame", in_frame, 0);
    chk("midrst_credit", $signed(credit), 0);
    chk("midrst_neg", credit_negative, 0);
    sb_q.delete();
    tick();
    rstn          = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    drive_beat(16'hD100, 2'b10, 1'b1);
    #2;
    chk("post_rst_in_frame", in_frame, 0);
    chk("post_rst_tvalid", m_axis_tvalid, 1);
    chk("post_rst_credit", $signed(credit), 0);
    tick();
    s_axis_tvalid = 1'b0;
    #2;
    chk("single_beat_idle", in_frame, 0);
    chk("single_beat_credit", $signed(credit), -3);

    repeat (2) tick();
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
